// File: rtl/sao2_core_arbiter.sv
// Round-robin front end for a shared combinational sao2 core: accepts one request at a time,
// registers it into the core, captures the result a cycle later and returns it tagged.
module sao2_core_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IN_W  = 10,
  parameter int unsigned OUT_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*IN_W-1:0]     req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [IN_W-1:0]          core_in,
  input  logic [OUT_W-1:0]         core_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [OUT_W-1:0]         rsp_data,
  output logic [CNT_W-1:0]         served_cnt,
  output logic                     busy
);

  localparam int unsigned IdW = $clog2(NREQ);

  typedef enum logic [1:0] {StIdle, StEval, StResp} state_e;

  state_e             state_q;
  logic [IdW-1:0]     ptr_q;
  logic [IdW-1:0]     tag_q;
  logic [IN_W-1:0]    core_in_q;
  logic               rsp_valid_q;
  logic [IdW-1:0]     rsp_id_q;
  logic [OUT_W-1:0]   rsp_data_q;
  logic [CNT_W-1:0]   served_q;

  logic [IdW-1:0]     grant_idx;
  logic [IdW-1:0]     cand;
  logic               found;
  logic               accept_en;
  logic               transfer;

  // Search starts one past the last winner so the last-served requester gets lowest priority.
  always_comb begin
    grant_idx = ptr_q;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      cand = IdW'((int'(ptr_q) + k) % int'(NREQ));
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign accept_en = (state_q == StIdle) || ((state_q == StResp) && rsp_ready);
  assign transfer  = rst_n && accept_en && found;
  assign req_ready = transfer ? (NREQ'(1) << grant_idx) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= IdW'(NREQ - 1);
      tag_q       <= '0;
      core_in_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      served_q    <= '0;
    end else begin
      if (transfer) begin
        core_in_q <= req_data[grant_idx*IN_W +: IN_W];
        tag_q     <= grant_idx;
        ptr_q     <= grant_idx;
      end
      unique case (state_q)
        StIdle: begin
          if (transfer) state_q <= StEval;
        end
        StEval: begin
          rsp_data_q  <= core_out;
          rsp_id_q    <= tag_q;
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (served_q != '1) served_q <= served_q + 1'b1;
            state_q <= transfer ? StEval : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign core_in    = core_in_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign served_cnt = served_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_sao2_core_arbiter.sv
// Directed bench for sao2_core_arbiter; a stand-in combinational core closes the loop and the
// same function serves as the golden result model.
module tb_sao2_core_arbiter;

  localparam int NREQ  = 4;
  localparam int IN_W  = 10;
  localparam int OUT_W = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*IN_W-1:0]  req_data;
  logic                  rsp_ready;

  logic [NREQ-1:0]       req_ready,  req_ready_s;
  logic [IN_W-1:0]       core_in,    core_in_s;
  logic [OUT_W-1:0]      core_out,   core_out_s;
  logic                  rsp_valid,  rsp_valid_s;
  logic [1:0]            rsp_id,     rsp_id_s;
  logic [OUT_W-1:0]      rsp_data,   rsp_data_s;
  logic [15:0]           served_cnt;
  logic [3:0]            served_s;
  logic                  busy,       busy_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] sao2(input logic [9:0] v);
    logic [3:0] r;
    r[0] = ^v[4:0] ^ v[9];
    r[1] = (v[0] & v[3]) | (v[6] ^ v[8]);
    r[2] = (|v[9:7]) & ~v[2];
    r[3] = ^v ^ v[5];
    return r;
  endfunction

  assign core_out   = sao2(core_in);
  assign core_out_s = sao2(core_in_s);

  sao2_core_arbiter #(.NREQ(4), .IN_W(10), .OUT_W(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .core_in    (core_in),
    .core_out   (core_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .served_cnt (served_cnt),
    .busy       (busy)
  );

  // Narrow-counter copy sharing all stimulus, used for saturation.
  sao2_core_arbiter #(.NREQ(4), .IN_W(10), .OUT_W(4), .CNT_W(4)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready_s),
    .core_in    (core_in_s),
    .core_out   (core_out_s),
    .rsp_valid  (rsp_valid_s),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id_s),
    .rsp_data   (rsp_data_s),
    .served_cnt (served_s),
    .busy       (busy_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] word(input int r);
    return req_data[r*IN_W +: IN_W];
  endfunction

  task automatic do_txn(input int r, input logic [9:0] v);
    int n;
    req_data[r*IN_W +: IN_W] = v;
    req_valid = 4'(1 << r);
    rsp_ready = 1'b1;
    #1;
    n = 0;
    while (!req_ready[r] && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("acc_timeout", 32'(n < 8), 32'd1);
    @(negedge clk);
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("rsp_timeout", 32'(n < 8), 32'd1);
    check("sweep_id", 32'(rsp_id), 32'(r));
    check("sweep_data", 32'(rsp_data), 32'(sao2(v)));
    @(negedge clk);
  endtask

  initial begin
    int g;
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_data  = {10'h2AA, 10'h155, 10'h30F, 10'h0F0};
    rsp_ready = 1'b1;

    // Reset: no accept even with every requester valid.
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("rst_ready2", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_core_in", 32'(core_in), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_served", 32'(served_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n     = 1'b1;
    req_valid = '0;

    // Single request from requester 2.
    @(negedge clk);
    req_data[2*IN_W +: IN_W] = 10'h155;
    req_valid = 4'b0100;
    #1 check("single_ready", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid = '0;
    check("single_core_in", 32'(core_in), 32'h155);
    check("single_busy", 32'(busy), 32'd1);
    check("single_early_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("single_valid", 32'(rsp_valid), 32'd1);
    check("single_id", 32'(rsp_id), 32'd2);
    check("single_data", 32'(rsp_data), 32'(sao2(10'h155)));
    check("single_served0", 32'(served_cnt), 32'd0);
    @(negedge clk);
    check("single_served1", 32'(served_cnt), 32'd1);
    check("single_valid_drop", 32'(rsp_valid), 32'd0);
    check("single_idle", 32'(busy), 32'd0);

    // Round robin from reset: 0,1,2,3,0,1, one grant every two cycles.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    req_data  = {10'h2AA, 10'h155, 10'h30F, 10'h0F0};
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      g = n % 4;
      #1 check("rr_grant", 32'(req_ready), 32'(1 << g));
      @(negedge clk);
      check("rr_core_in", 32'(core_in), 32'(word(g)));
      check("rr_eval_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("rr_valid", 32'(rsp_valid), 32'd1);
      check("rr_id", 32'(rsp_id), 32'(g));
      check("rr_data", 32'(rsp_data), 32'(sao2(word(g))));
    end

    // Backpressure in RESP holding requester 1's result.
    rsp_ready = 1'b0;
    #1;
    for (int n = 0; n < 5; n++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_id", 32'(rsp_id), 32'd1);
      check("bp_data", 32'(rsp_data), 32'(sao2(word(1))));
      check("bp_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 check("bp_release_grant", 32'(req_ready), 32'b0100);
    @(negedge clk);
    check("bp_core_in", 32'(core_in), 32'(word(2)));
    check("bp_no_bubble", 32'(busy), 32'd1);
    check("bp_valid_drop", 32'(rsp_valid), 32'd0);
    check("bp_served", 32'(served_cnt), 32'd6);
    @(negedge clk);
    check("pre_rst_id", 32'(rsp_id), 32'd2);
    check("pre_rst_grant", 32'(req_ready), 32'b1000);

    // Reset while evaluating requester 3's vector.
    @(negedge clk);
    check("mid_core_in", 32'(core_in), 32'(word(3)));
    rst_n = 1'b0;
    #1 check("mid_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_served", 32'(served_cnt), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_core_in0", 32'(core_in), 32'd0);
    rst_n = 1'b1;
    #1 check("mid_next_grant", 32'(req_ready), 32'b0001);
    @(negedge clk);
    check("mid_core_in_r0", 32'(core_in), 32'(word(0)));
    check("mid_no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("mid_rsp_id", 32'(rsp_id), 32'd0);
    req_valid = '0;
    @(negedge clk);

    // Exhaustive sweep; the narrow counter saturates along the way.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int v = 0; v < 1024; v++) begin
      do_txn(v % 4, 10'(v));
      if (v == 14) begin
        check("sat_at15", 32'(served_s), 32'd15);
        check("wide_at15", 32'(served_cnt), 32'd15);
      end
      if (v == 19) begin
        check("sat_at20", 32'(served_s), 32'd15);
        check("wide_at20", 32'(served_cnt), 32'd20);
      end
    end
    check("sweep_served", 32'(served_cnt), 32'd1024);
    check("sweep_sat", 32'(served_s), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
